// File: rtl/state_dump_reader.sv
// state_dump_reader
//   After a program run, walks the register file and then data memory
//   through their debug read ports and streams every word out over a
//   valid/ready interface. Words go to a checker, logger or host link
//   that compares the final architectural state against expected images.
//   The block only reads; it drives no write enables.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle dump request, honoured only when idle
//   rf_raddr     register-file debug read address (RF phase only, else 0)
//   rf_rdata     register-file read data, combinational from rf_raddr
//   ram_raddr    data-memory debug word address (RAM phase only, else 0)
//   ram_rdata    data-memory read data, combinational from ram_raddr
//   dout_valid   output word valid
//   dout_ready   consumer accepts the word
//   dout_data    dumped word
//   dout_src     0 = register file, 1 = RAM
//   dout_idx     source index (RF index zero-extended)
//   busy         high from accepted start until the done cycle
//   done         one-cycle pulse after the final word is accepted
module state_dump_reader #(
  parameter int RF_WORDS  = 32,
  parameter int RAM_WORDS = 64,
  parameter int RAM_AW    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [4:0]        rf_raddr,
  input  logic [31:0]       rf_rdata,
  output logic [RAM_AW-1:0] ram_raddr,
  input  logic [31:0]       ram_rdata,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [31:0]       dout_data,
  output logic              dout_src,
  output logic [RAM_AW-1:0] dout_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    DUMP_RF,
    DUMP_RAM,
    DRAIN,
    DONE
  } state_t;

  localparam logic [RAM_AW-1:0] RF_LAST  = RAM_AW'(RF_WORDS - 1);
  localparam logic [RAM_AW-1:0] RAM_LAST = RAM_AW'(RAM_WORDS - 1);

  state_t              state_q, state_d;
  logic [RAM_AW-1:0]   idx_q, idx_d;
  logic                dout_valid_q, dout_valid_d;
  logic [31:0]         dout_data_q, dout_data_d;
  logic                dout_src_q, dout_src_d;
  logic [RAM_AW-1:0]   dout_idx_q, dout_idx_d;
  logic                load;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    dout_valid_d = dout_valid_q;
    dout_data_d  = dout_data_q;
    dout_src_d   = dout_src_q;
    dout_idx_d   = dout_idx_q;
    rf_raddr     = '0;
    ram_raddr    = '0;

    // A new word may enter the output register when it is empty or when
    // the word it holds is being accepted this cycle.
    load = ((state_q == DUMP_RF) || (state_q == DUMP_RAM)) &&
           (!dout_valid_q || dout_ready);

    if (state_q == DUMP_RF)  rf_raddr  = idx_q[4:0];
    if (state_q == DUMP_RAM) ram_raddr = idx_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DUMP_RF;
          idx_d   = '0;
        end
      end
      DUMP_RF: begin
        if (load) begin
          dout_data_d  = rf_rdata;
          dout_src_d   = 1'b0;
          dout_idx_d   = idx_q;
          dout_valid_d = 1'b1;
          // Terminal compare before increment: the counter never wraps.
          if (idx_q == RF_LAST) begin
            state_d = DUMP_RAM;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DUMP_RAM: begin
        if (load) begin
          dout_data_d  = ram_rdata;
          dout_src_d   = 1'b1;
          dout_idx_d   = idx_q;
          dout_valid_d = 1'b1;
          if (idx_q == RAM_LAST) begin
            state_d = DRAIN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // Last word sits in the output register until it is accepted.
        if (dout_valid_q && dout_ready) begin
          dout_valid_d = 1'b0;
          state_d      = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
      dout_src_q   <= 1'b0;
      dout_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      dout_valid_q <= dout_valid_d;
      dout_data_q  <= dout_data_d;
      dout_src_q   <= dout_src_d;
      dout_idx_q   <= dout_idx_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_data  = dout_data_q;
  assign dout_src   = dout_src_q;
  assign dout_idx   = dout_idx_q;
  assign busy       = (state_q == DUMP_RF) || (state_q == DUMP_RAM) ||
                      (state_q == DRAIN);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_state_dump_reader.sv
module tb_state_dump_reader;

  logic clk;
  logic rst_n;

  // Default-size instance
  logic        start_a, ready_a;
  logic [4:0]  rf_raddr_a;
  logic [31:0] rf_rdata_a, ram_rdata_a, dout_data_a;
  logic [5:0]  ram_raddr_a, dout_idx_a;
  logic        dout_valid_a, dout_src_a, busy_a, done_a;

  // Small instance
  logic        start_b, ready_b;
  logic [4:0]  rf_raddr_b;
  logic [31:0] rf_rdata_b, ram_rdata_b, dout_data_b;
  logic [4:0]  ram_raddr_b, dout_idx_b;
  logic        dout_valid_b, dout_src_b, busy_b, done_b;

  assign rf_rdata_a  = 32'h100  + {27'b0, rf_raddr_a};
  assign ram_rdata_a = 32'hA000 + {26'b0, ram_raddr_a};
  assign rf_rdata_b  = 32'h100  + {27'b0, rf_raddr_b};
  assign ram_rdata_b = 32'hA000 + {27'b0, ram_raddr_b};

  state_dump_reader dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .rf_raddr(rf_raddr_a), .rf_rdata(rf_rdata_a),
    .ram_raddr(ram_raddr_a), .ram_rdata(ram_rdata_a),
    .dout_valid(dout_valid_a), .dout_ready(ready_a),
    .dout_data(dout_data_a), .dout_src(dout_src_a), .dout_idx(dout_idx_a),
    .busy(busy_a), .done(done_a)
  );

  state_dump_reader #(.RF_WORDS(4), .RAM_WORDS(5), .RAM_AW(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .rf_raddr(rf_raddr_b), .rf_rdata(rf_rdata_b),
    .ram_raddr(ram_raddr_b), .ram_rdata(ram_rdata_b),
    .dout_valid(dout_valid_b), .dout_ready(ready_b),
    .dout_data(dout_data_b), .dout_src(dout_src_b), .dout_idx(dout_idx_b),
    .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [38:0] got_w [0:199];
  int n_got, done_cnt, first_valid, done_cyc;
  logic [4:0] max_ram_b = '0;

  always @(negedge clk) if (ram_raddr_b > max_ram_b) max_ram_b <= ram_raddr_b;

  typedef struct {
    int          word;
    logic        src;
    logic [5:0]  idx;
    logic [31:0] data;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [38:0] exp_word(input int k, input int rfw);
    if (k < rfw) return {1'b0, 6'(k), 32'h100 + 32'(k)};
    return {1'b1, 6'(k - rfw), 32'hA000 + 32'(k - rfw)};
  endfunction

  // mode 0: ready always high; mode 1: 5-cycle stall on RF[3] then a
  // deterministic irregular ready pattern. ign pulses start at words 10/50.
  // b2b pulses start in the done cycle and returns in the following cycle.
  task automatic run_dump(input int mode, input bit ign, input bit b2b);
    int  stall;
    int  post;
    bit  seen_done, stall_now, ign10, ign50;
    stall = 0; post = 0; seen_done = 0; ign10 = 0; ign50 = 0;
    n_got = 0; done_cnt = 0; first_valid = -1; done_cyc = -1;
    start_a = 1'b1; ready_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check("busy_after_start", 64'(busy_a), 64'd1);
    for (int c = 0; c < 800; c++) begin
      start_a = 1'b0;
      stall_now = 0;
      if (mode == 0) begin
        ready_a = 1'b1;
      end else if (dout_valid_a && !dout_src_a && dout_idx_a == 6'd3 && stall < 5) begin
        ready_a = 1'b0;
        stall++;
        stall_now = 1;
      end else begin
        ready_a = ((c * 7) % 5) != 0;
      end
      if (ign && n_got == 10 && !ign10) begin start_a = 1'b1; ign10 = 1; end
      if (ign && n_got == 50 && !ign50) begin start_a = 1'b1; ign50 = 1; end
      if (b2b && done_a) start_a = 1'b1;
      @(negedge clk);
      if (stall_now) begin
        check("stall_data",  64'(dout_data_a),  64'h103);
        check("stall_idx",   64'(dout_idx_a),   64'd3);
        check("stall_valid", 64'(dout_valid_a), 64'd1);
      end
      if (dout_valid_a && first_valid < 0) first_valid = c;
      if (dout_valid_a && ready_a) begin
        if (n_got < 200) got_w[n_got] = {dout_src_a, dout_idx_a, dout_data_a};
        n_got++;
      end
      if (done_a) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
        check("busy_in_done", 64'(busy_a), 64'd0);
        seen_done = 1;
      end
      @(posedge clk); #1;
      if (seen_done) begin
        if (b2b) begin
          check("b2b_start_ignored", 64'(busy_a), 64'd0);
          break;
        end
        post++;
        if (post > 3) break;
      end
    end
    start_a = 1'b0;
    if (!seen_done) check("done_timeout", 64'd0, 64'd1);
    check("word_count", 64'(n_got), 64'd96);
    check("done_pulses", 64'(done_cnt), 64'd1);
    for (int k = 0; k < 96 && k < n_got; k++)
      check($sformatf("word%0d", k), 64'(got_w[k]), 64'(exp_word(k, 32)));
  endtask

  initial begin
    bit found;
    vecs[0] = '{0,  1'b0, 6'd0,  32'h100};
    vecs[1] = '{1,  1'b0, 6'd1,  32'h101};
    vecs[2] = '{31, 1'b0, 6'd31, 32'h11F};
    vecs[3] = '{32, 1'b1, 6'd0,  32'hA000};
    vecs[4] = '{33, 1'b1, 6'd1,  32'hA001};
    vecs[5] = '{95, 1'b1, 6'd63, 32'hA03F};

    rst_n = 1'b0; start_a = 1'b0; ready_a = 1'b1; start_b = 1'b0; ready_b = 1'b1;
    #1;
    check("rst_valid", 64'(dout_valid_a), 64'd0);
    check("rst_busy",  64'(busy_a),       64'd0);
    check("rst_done",  64'(done_a),       64'd0);
    check("rst_data",  64'(dout_data_a),  64'd0);
    check("rst_raddr", 64'({rf_raddr_a, ram_raddr_a}), 64'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // Free-flow
    run_dump(0, 0, 0);
    for (int i = 0; i < 6; i++)
      check($sformatf("vec%0d", i), 64'(got_w[vecs[i].word]),
            64'({vecs[i].src, vecs[i].idx, vecs[i].data}));
    check("first_valid_cycle", 64'(first_valid), 64'd1);
    check("done_cycle", 64'(done_cyc), 64'd97);

    // Backpressure with irregular ready
    run_dump(1, 0, 0);
    check("bp_word4", 64'(got_w[4]), 64'({1'b0, 6'd4, 32'h104}));

    // Ignored start pulses mid-dump
    run_dump(0, 1, 0);

    // Asynchronous reset during RAM word 20
    start_a = 1'b1; ready_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    found = 0;
    for (int c = 0; c < 200; c++) begin
      if (dout_valid_a && dout_src_a && dout_idx_a == 6'd20) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("reach_ram20", 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(dout_valid_a), 64'd0);
    check("mid_rst_busy",  64'(busy_a),       64'd0);
    check("mid_rst_done",  64'(done_a),       64'd0);
    check("mid_rst_out",   64'({dout_src_a, dout_idx_a, dout_data_a}), 64'd0);
    check("mid_rst_raddr", 64'({rf_raddr_a, ram_raddr_a}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", 64'(busy_a), 64'd0);
    run_dump(0, 0, 0);

    // Small-parameter instance
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    n_got = 0; done_cyc = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (dout_valid_b) begin
        check($sformatf("small_word%0d", n_got),
              64'({dout_src_b, 1'b0, dout_idx_b, dout_data_b}), 64'(exp_word(n_got, 4)));
        n_got++;
      end
      if (done_b) begin
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    check("small_count", 64'(n_got), 64'd9);
    check("small_done_cycle", 64'(done_cyc), 64'd10);
    check("small_ram_max", 64'(max_ram_b), 64'd4);
    @(posedge clk); #1;

    // Back-to-back: start in done cycle ignored, next cycle accepted
    run_dump(0, 0, 1);
    run_dump(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
